// File: rtl/alu_sequencer.sv
// Execute-stage sequencer wrapping an external 32-bit ALU. It issues the ALU select and operands,
// builds SLT/SLTU from the subtract flags, and runs shifts one bit per cycle.
// Optional macro ALU_SEQ_BARREL_SHIFT_EN swaps the iterative shifter for a single-cycle barrel shift.
module alu_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [3:0]      alu_gsel,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_g,
  input  logic [3:0]      alu_flags,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [3:0]      out_flags
);
  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b1000, OP_SLL = 4'b0001, OP_SLT = 4'b0010,
                         OP_SLTU = 4'b0011, OP_XOR = 4'b0100, OP_SRL = 4'b0101, OP_SRA = 4'b1101,
                         OP_OR = 4'b0110, OP_AND = 4'b0111;
  localparam logic [3:0] G_ADD = 4'b0000, G_SUB = 4'b0001, G_XOR = 4'b1000, G_OR = 4'b1100,
                         G_AND = 4'b1110;

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

  state_t          state, state_nx;
  logic [3:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, shreg, shreg_nx, sh_step, res_nx;
  logic [4:0]      cnt, cnt_nx, shamt;
  logic [3:0]      flg_nx;

  assign shamt     = b_q[4:0];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

`ifdef ALU_SEQ_BARREL_SHIFT_EN
  logic [XLEN-1:0] barrel;
  always_comb begin
    case (op_q)
      OP_SLL:  barrel = a_q << shamt;
      OP_SRA:  barrel = $signed(a_q) >>> shamt;
      default: barrel = a_q >> shamt;
    endcase
  end
`endif

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = cnt;
    res_nx   = result;
    flg_nx   = out_flags;
    alu_gsel = G_ADD;
    alu_a    = '0;
    alu_b    = '0;
    sh_step  = '0;
    case (state)
      IDLE: if (in_valid) state_nx = EXEC;
      EXEC: begin
        state_nx = DONE;
        alu_a    = a_q;
        alu_b    = b_q;
        case (op_q)
          OP_ADD, OP_SUB: begin
            alu_gsel = (op_q == OP_SUB) ? G_SUB : G_ADD;
            res_nx   = alu_g;
            flg_nx   = alu_flags;
          end
          // A + ~B + 1: signed less-than is N^V, unsigned borrow is ~C
          OP_SLT, OP_SLTU: begin
            alu_gsel = G_SUB;
            res_nx   = {{(XLEN-1){1'b0}},
                        (op_q == OP_SLT) ? (alu_flags[1] ^ alu_flags[0]) : ~alu_flags[2]};
            flg_nx   = alu_flags;
          end
          OP_XOR, OP_OR, OP_AND: begin
            alu_gsel = (op_q == OP_XOR) ? G_XOR : (op_q == OP_OR) ? G_OR : G_AND;
            res_nx   = alu_g;
            flg_nx   = {alu_g == '0, 3'b000};
          end
          OP_SLL, OP_SRL, OP_SRA: begin
            alu_a = '0;
            alu_b = '0;
`ifdef ALU_SEQ_BARREL_SHIFT_EN
            res_nx = barrel;
            flg_nx = {barrel == '0, 3'b000};
`else
            if (shamt == '0) begin
              res_nx = a_q;
              flg_nx = {a_q == '0, 3'b000};
            end else begin
              shreg_nx = a_q;
              cnt_nx   = shamt;
              state_nx = SHIFT;
            end
`endif
          end
          default: begin
            alu_a  = '0;
            alu_b  = '0;
            res_nx = '0;
            flg_nx = 4'b0000;
          end
        endcase
      end
      SHIFT: begin
        case (op_q)
          // left shift by one is shreg + shreg through the ALU adder
          OP_SLL: begin
            alu_a   = shreg;
            alu_b   = shreg;
            sh_step = alu_g;
          end
          OP_SRA:  sh_step = {shreg[XLEN-1], shreg[XLEN-1:1]};
          default: sh_step = {1'b0, shreg[XLEN-1:1]};
        endcase
        shreg_nx = sh_step;
        cnt_nx   = cnt - 5'd1;
        if (cnt == 5'd1) begin
          res_nx   = sh_step;
          flg_nx   = {sh_step == '0, 3'b000};
          state_nx = DONE;
        end
      end
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      shreg     <= '0;
      cnt       <= '0;
      result    <= '0;
      out_flags <= '0;
    end else begin
      state     <= state_nx;
      shreg     <= shreg_nx;
      cnt       <= cnt_nx;
      result    <= res_nx;
      out_flags <= flg_nx;
      if (state == IDLE && in_valid) begin
        op_q <= op;
        a_q  <= rs1;
        b_q  <= rs2;
      end
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized scoreboard bench for alu_sequencer with a behavioural ALU and reference model.
// Honours ALU_SEQ_BARREL_SHIFT_EN for expected shift latency.
module tb_alu_sequencer;
  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [3:0]  op = 0, alu_gsel, alu_flags, out_flags;
  logic [31:0] rs1 = 0, rs2 = 0, alu_a, alu_b, alu_g, result;

  typedef struct {logic [31:0] res; logic [3:0] flg; int due;} exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, hold = 0;
  bit seen = 0;
  logic [31:0] hold_res;
  logic [3:0]  hold_flg;

  alu_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .rs1(rs1), .rs2(rs2), .alu_gsel(alu_gsel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_g(alu_g), .alu_flags(alu_flags), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_flags(out_flags));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural ALU the sequencer drives
  logic [32:0] sum;
  always_comb begin
    sum = '0;
    alu_flags = '0;
    case (alu_gsel)
      4'b0000: sum = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0001: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      4'b1000: sum = {1'b0, alu_a ^ alu_b};
      4'b1100: sum = {1'b0, alu_a | alu_b};
      4'b1110: sum = {1'b0, alu_a & alu_b};
      default: sum = '0;
    endcase
    alu_g = sum[31:0];
    alu_flags[3] = (alu_g == 0);
    alu_flags[2] = sum[32];
    alu_flags[1] = alu_g[31];
    if (alu_gsel == 4'b0000) alu_flags[0] = (alu_a[31] == alu_b[31]) && (alu_g[31] != alu_a[31]);
    if (alu_gsel == 4'b0001) alu_flags[0] = (alu_a[31] != alu_b[31]) && (alu_g[31] != alu_a[31]);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit ovf(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // reference model straight from the RV32I rules with wide integer arithmetic
  task automatic ref_model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic [3:0] f, output int lat);
    longint sa = longint'($signed(a)), sb = longint'($signed(b));
    longint ua = longint'(a), ub = longint'(b);
    int sh = int'(b[4:0]);
    logic [3:0] subf = {a == b, ua >= ub, 1'(((a - b) >> 31)), ovf(sa - sb)};
    lat = 1;
    r = 0;
    f = 0;
    case (o)
      4'b0000: begin r = a + b; f = {r == 0, ua + ub > 64'hFFFFFFFF, r[31], ovf(sa + sb)}; end
      4'b1000: begin r = a - b; f = subf; end
      4'b0010: begin r = (sa < sb) ? 1 : 0; f = subf; end
      4'b0011: begin r = (ua < ub) ? 1 : 0; f = subf; end
      4'b0100: r = a ^ b;
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      4'b0001: r = a << sh;
      4'b0101: r = a >> sh;
      4'b1101: r = 32'($signed(a) >>> sh);
      default: ;
    endcase
    if (o inside {4'b0100, 4'b0110, 4'b0111, 4'b0001, 4'b0101, 4'b1101}) f = {r == 0, 3'b000};
`ifndef ALU_SEQ_BARREL_SHIFT_EN
    if (o inside {4'b0001, 4'b0101, 4'b1101}) lat = 1 + sh;
`endif
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    int w = 0;
    exp_t e;
    logic [3:0] g;
    @(negedge clk);
    while (!in_ready && w < 400) begin @(negedge clk); w++; end
    if (!in_ready) begin chk("in_ready_timeout", 32'(in_ready), 1); return; end
    in_valid = 1; op = o; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    in_valid = 0; op = 4'($urandom); rs1 = $urandom; rs2 = $urandom;
    ref_model(o, a, b, e.res, e.flg, e.due);
    e.due += cyc;
    exp_q.push_back(e);
    g = 4'hF;
    case (o)
      4'b0000: g = 4'b0000;
      4'b1000, 4'b0010, 4'b0011: g = 4'b0001;
      4'b0100: g = 4'b1000;
      4'b0110: g = 4'b1100;
      4'b0111: g = 4'b1110;
      default: ;
    endcase
    if (g != 4'hF) begin
      chk("exec_gsel", 32'(alu_gsel), 32'(g));
      chk("exec_alu_a", alu_a, a);
      chk("exec_alu_b", alu_b, b);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (hold > 0) begin out_ready = 0; hold--; end
    else out_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) seen = 0;
    else begin
      if (in_ready) begin
        chk("idle_gsel", 32'(alu_gsel), 0);
        chk("idle_alu_a", alu_a, 0);
      end
      if (out_valid) begin
        chk("in_ready_in_done", 32'(in_ready), 0);
        if (exp_q.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 0);
        else begin
          if (!seen) begin
            seen = 1; hold_res = result; hold_flg = out_flags;
            chk("latency_cycle", cyc, exp_q[0].due);
          end else begin
            chk("held_result", result, hold_res);
            chk("held_flags", 32'(out_flags), 32'(hold_flg));
          end
          if (out_ready) begin
            e = exp_q.pop_front();
            chk("result", result, e.res);
            chk("out_flags", 32'(out_flags), 32'(e.flg));
            seen = 0;
          end
        end
      end
    end
  end

  initial begin
    #3;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result", result, 0);
    chk("rst_flags", 32'(out_flags), 0);
    chk("rst_gsel", 32'(alu_gsel), 0);
    chk("rst_alu_b", alu_b, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    issue(4'b0000, 32'h7FFFFFFF, 32'd1);
    issue(4'b0010, 32'hFFFFFFFE, 32'd3);
    issue(4'b0011, 32'hFFFFFFFE, 32'd3);
    issue(4'b0001, 32'h00000003, 32'd4);
    issue(4'b1101, 32'h80000000, 32'd31);
    issue(4'b0101, 32'h12345678, 32'hFFFFFFE0);
    hold = 8;
    issue(4'b0111, 32'hF0F0F0F0, 32'h0F0F0F0F);
    issue(4'b1111, 32'h11111111, 32'h22222222);
    issue(4'b1000, 32'h80000000, 32'd1);

    // reset in the middle of a long SRL: the op vanishes
    issue(4'b0101, 32'hDEADBEEF, 32'd20);
    repeat (6) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_result", result, 0);
    chk("abort_flags", 32'(out_flags), 0);
    chk("abort_in_ready", 32'(in_ready), 1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1;
    issue(4'b0100, 32'h000000FF, 32'h0000000F);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] b = $urandom;
      if ($urandom_range(0, 3) == 0) b[4:0] = 5'd0;
      issue(4'($urandom), $urandom, b);
    end

    begin
      int w = 0;
      while (exp_q.size() > 0 && w < 3000) begin @(negedge clk); w++; end
      if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
